// File: rtl/exec_unit_if.sv
// exec_unit_if: request/result bundle between the register file side and exec_unit.
// The master drives the request (start, Op, operands, destination); the slave
// returns busy and the write-back (ALUResult, WriteReg, RegWrite, Zero).
interface exec_unit_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
);
    logic              start;
    logic [2:0]        Op;
    logic [WIDTH-1:0]  SrcA;
    logic [WIDTH-1:0]  SrcB;
    logic [ADDR_W-1:0] Rd;
    logic              busy;
    logic [WIDTH-1:0]  ALUResult;
    logic [ADDR_W-1:0] WriteReg;
    logic              RegWrite;
    logic              Zero;

    modport master (
        output start, Op, SrcA, SrcB, Rd,
        input  busy, ALUResult, WriteReg, RegWrite, Zero
    );

    modport slave (
        input  start, Op, SrcA, SrcB, Rd,
        output busy, ALUResult, WriteReg, RegWrite, Zero
    );
endinterface

// File: rtl/exec_unit.sv
// exec_unit: execute stage feeding the register file write port.
// ADD/SUB/AND/ORR/EOR finish in one cycle; MUL (shift-add) and, when the DIV_EN
// macro is defined, UDIV/UMOD (restoring division) take WIDTH cycles behind busy.
// Without DIV_EN, Op 110/111 are single-cycle ops returning zero.
// Reset: rst is asynchronous and active-low.
module exec_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    exec_unit_if.slave  bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ITER = 1'b1;
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_count;
    // r_opA: multiplicand (MUL) or dividend-shifting-into-quotient (DIV)
    // r_opB: multiplier (MUL) or divisor (DIV)
    // r_acc: product accumulator (MUL) or partial remainder (DIV)
    logic [WIDTH-1:0]  r_opA;
    logic [WIDTH-1:0]  r_opB;
    logic [WIDTH-1:0]  r_acc;
    logic [ADDR_W-1:0] r_rd;
    logic [WIDTH-1:0]  r_result;
    logic [ADDR_W-1:0] r_writeReg;
    logic              r_regWrite;
    logic              r_zero;
`ifdef DIV_EN
    logic              r_isDiv;
    logic              r_isMod;
    logic [WIDTH:0]    w_shift;
    logic              w_qbit;
    logic [WIDTH-1:0]  w_remNext;
    logic [WIDTH-1:0]  w_quoNext;
`endif

    logic [WIDTH-1:0]  w_logicResult;
    logic              w_isMulti;
    logic [WIDTH-1:0]  w_mulAcc;
    logic [WIDTH-1:0]  w_stepA;
    logic [WIDTH-1:0]  w_stepB;
    logic [WIDTH-1:0]  w_stepAcc;
    logic [WIDTH-1:0]  w_finalResult;

    assign bus.busy      = (r_state == S_ITER);
    assign bus.ALUResult = r_result;
    assign bus.WriteReg  = r_writeReg;
    assign bus.RegWrite  = r_regWrite;
    assign bus.Zero      = r_zero;

    // Decode the incoming op: single-cycle result, or flag it as iterative
    always_comb begin
        w_isMulti     = 1'b0;
        w_logicResult = '0;
        case (bus.Op)
            3'b000:  w_logicResult = bus.SrcA + bus.SrcB;
            3'b001:  w_logicResult = bus.SrcA - bus.SrcB;
            3'b010:  w_logicResult = bus.SrcA & bus.SrcB;
            3'b011:  w_logicResult = bus.SrcA | bus.SrcB;
            3'b100:  w_logicResult = bus.SrcA ^ bus.SrcB;
            3'b101:  w_isMulti     = 1'b1;
`ifdef DIV_EN
            3'b110,
            3'b111:  w_isMulti     = 1'b1;
`endif
            default: w_logicResult = '0;
        endcase
    end

    // One iteration step of the shared multiply / divide datapath
    always_comb begin
        w_mulAcc      = r_acc + (r_opB[0] ? r_opA : '0);
        w_stepA       = r_opA << 1;
        w_stepB       = r_opB >> 1;
        w_stepAcc     = w_mulAcc;
        w_finalResult = w_mulAcc;
`ifdef DIV_EN
        // Bring the next dividend bit into the remainder; subtract if it fits.
        // A zero divisor always "fits", giving all-ones quotient and remainder=dividend.
        w_shift   = {r_acc, r_opA[WIDTH-1]};
        w_qbit    = (w_shift >= {1'b0, r_opB});
        w_remNext = w_qbit ? (w_shift[WIDTH-1:0] - r_opB) : w_shift[WIDTH-1:0];
        w_quoNext = {r_opA[WIDTH-2:0], w_qbit};
        if (r_isDiv) begin
            w_stepA       = w_quoNext;
            w_stepB       = r_opB;
            w_stepAcc     = w_remNext;
            w_finalResult = r_isMod ? w_remNext : w_quoNext;
        end
`endif
    end

    // Control FSM, operand latching, iteration and write-back strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_opA      <= '0;
            r_opB      <= '0;
            r_acc      <= '0;
            r_rd       <= '0;
            r_result   <= '0;
            r_writeReg <= '0;
            r_regWrite <= 1'b0;
            r_zero     <= 1'b0;
`ifdef DIV_EN
            r_isDiv    <= 1'b0;
            r_isMod    <= 1'b0;
`endif
        end else begin
            r_regWrite <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_isMulti) begin
                            r_state <= S_ITER;
                            r_count <= '0;
                            r_opA   <= bus.SrcA;
                            r_opB   <= bus.SrcB;
                            r_acc   <= '0;
                            r_rd    <= bus.Rd;
`ifdef DIV_EN
                            r_isDiv <= (bus.Op[2:1] == 2'b11);
                            r_isMod <= (bus.Op == 3'b111);
`endif
                        end else begin
                            r_result   <= w_logicResult;
                            r_writeReg <= bus.Rd;
                            r_zero     <= (w_logicResult == '0);
                            r_regWrite <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_opA   <= w_stepA;
                    r_opB   <= w_stepB;
                    r_acc   <= w_stepAcc;
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_STEP) begin
                        r_state    <= S_IDLE;
                        r_result   <= w_finalResult;
                        r_writeReg <= r_rd;
                        r_zero     <= (w_finalResult == '0);
                        r_regWrite <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed bench for exec_unit with a cycle-level reference model.
// Honours the DIV_EN macro the same way the design does.
module tb_exec_unit;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nChecks = 0;
    int   nErrors = 0;
    bit   checkEn = 1'b0;

    exec_unit_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    exec_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: outputs plus a countdown for the pending long op
    int          mBusyLeft = 0;
    logic [31:0] mResult   = '0;
    logic [31:0] mPend     = '0;
    logic [3:0]  mRd       = '0;
    logic [3:0]  mPendRd   = '0;
    logic        mRegWrite = 1'b0;
    logic        mZero     = 1'b0;

    function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a * b;
`ifdef DIV_EN
            3'd6: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
`else
            default: return 32'd0;
`endif
        endcase
    endfunction

    function automatic bit isMultiCycle(input logic [2:0] op);
`ifdef DIV_EN
        return (op >= 3'd5);
`else
        return (op == 3'd5);
`endif
    endfunction

    // Model advances on each rising edge using the inputs presented before it
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mBusyLeft = 0;
            mResult   = '0;
            mRd       = '0;
            mRegWrite = 1'b0;
            mZero     = 1'b0;
        end else begin
            mRegWrite = 1'b0;
            if (mBusyLeft > 0) begin
                mBusyLeft = mBusyLeft - 1;
                if (mBusyLeft == 0) begin
                    mResult   = mPend;
                    mRd       = mPendRd;
                    mZero     = (mPend == 0);
                    mRegWrite = 1'b1;
                end
            end else if (bus.start) begin
                if (isMultiCycle(bus.Op)) begin
                    mBusyLeft = WIDTH;
                    mPend     = refResult(bus.Op, bus.SrcA, bus.SrcB);
                    mPendRd   = bus.Rd;
                end else begin
                    mResult   = refResult(bus.Op, bus.SrcA, bus.SrcB);
                    mRd       = bus.Rd;
                    mZero     = (mResult == 0);
                    mRegWrite = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every falling edge, compare all outputs with the model
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model busy",      32'(bus.busy),      32'(mBusyLeft > 0));
            checkOutput("model RegWrite",  32'(bus.RegWrite),  32'(mRegWrite));
            checkOutput("model ALUResult", bus.ALUResult,      mResult);
            checkOutput("model WriteReg",  32'(bus.WriteReg),  32'(mRd));
            checkOutput("model Zero",      32'(bus.Zero),      32'(mZero));
        end
    end

    // Present one request for exactly one rising edge, return at the following falling edge
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] rd);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.Op    = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
        bus.Rd    = rd;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    // Wait (bounded) for the write strobe, counting cycles spent busy
    task automatic waitDone(output int busyCycles);
        busyCycles = 0;
        for (int i = 0; i < 40 && !bus.RegWrite; i++) begin
            if (bus.busy) busyCycles++;
            @(negedge clk);
        end
        checkOutput("strobe seen", 32'(bus.RegWrite), 32'd1);
    endtask

    task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] rd, input logic [31:0] expResult, input int expBusy);
        int cycles;
        applyStimulus(op, a, b, rd);
        waitDone(cycles);
        checkOutput({name, " busy cycles"}, 32'(cycles), 32'(expBusy));
        checkOutput({name, " result"},      bus.ALUResult, expResult);
        checkOutput({name, " WriteReg"},    32'(bus.WriteReg), 32'(rd));
        checkOutput({name, " Zero"},        32'(bus.Zero), 32'(expResult == 0));
        @(negedge clk);
        checkOutput({name, " strobe drop"}, 32'(bus.RegWrite), 32'd0);
    endtask

    localparam int DIV_CYC = `ifdef DIV_EN 32 `else 0 `endif;

    initial begin
        bus.start = 1'b0;
        bus.Op    = 3'd0;
        bus.SrcA  = '0;
        bus.SrcB  = '0;
        bus.Rd    = '0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        checkEn = 1'b1;
        checkOutput("reset busy",      32'(bus.busy), 32'd0);
        checkOutput("reset RegWrite",  32'(bus.RegWrite), 32'd0);
        checkOutput("reset ALUResult", bus.ALUResult, 32'd0);
        checkOutput("reset WriteReg",  32'(bus.WriteReg), 32'd0);
        checkOutput("reset Zero",      32'(bus.Zero), 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Single-cycle ops
        runOp("ADD 5+7",  3'd0, 32'd5, 32'd7, 4'd2, 32'd12, 0);
        checkOutput("ADD held", bus.ALUResult, 32'd12);
        runOp("SUB 3-5",  3'd1, 32'd3, 32'd5, 4'd1, 32'hFFFF_FFFE, 0);
        runOp("SUB 9-9",  3'd1, 32'd9, 32'd9, 4'd3, 32'd0, 0);
        runOp("AND",      3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'd4, 32'h00F0_1234, 0);
        runOp("ORR",      3'd3, 32'hF000_0000, 32'h0000_000F, 4'd5, 32'hF000_000F, 0);
        runOp("EOR",      3'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd6, 32'hF0F0_F0F0, 0);

        // Back-to-back single-cycle ops keep the strobe high
        @(posedge clk); #1;
        bus.start = 1'b1; bus.Op = 3'd0; bus.SrcA = 32'd1;  bus.SrcB = 32'd1; bus.Rd = 4'd1;
        @(posedge clk); #1;
        bus.Op = 3'd1; bus.SrcA = 32'd10; bus.SrcB = 32'd4; bus.Rd = 4'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput("b2b RegWrite", 32'(bus.RegWrite), 32'd1);
        checkOutput("b2b result",   bus.ALUResult, 32'd6);
        checkOutput("b2b WriteReg", 32'(bus.WriteReg), 32'd2);

        // Iterative ops
        runOp("MUL 1234*5678", 3'd5, 32'd1234, 32'd5678, 4'd7, 32'd7006652, 32);
        runOp("MUL 2^16*2^16", 3'd5, 32'h0001_0000, 32'h0001_0000, 4'd8, 32'd0, 32);
        runOp("MUL max*max",   3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd9, 32'd1, 32);
`ifdef DIV_EN
        runOp("UDIV 100/7", 3'd6, 32'd100, 32'd7, 4'd10, 32'd14, DIV_CYC);
        runOp("UMOD 100/7", 3'd7, 32'd100, 32'd7, 4'd11, 32'd2, DIV_CYC);
        runOp("UDIV 5/0",   3'd6, 32'd5, 32'd0, 4'd12, 32'hFFFF_FFFF, DIV_CYC);
        runOp("UMOD 5/0",   3'd7, 32'd5, 32'd0, 4'd13, 32'd5, DIV_CYC);
        runOp("UDIV big",   3'd6, 32'hFFFF_FFFF, 32'd3, 4'd14, 32'h5555_5555, DIV_CYC);
`else
        runOp("UDIV 100/7", 3'd6, 32'd100, 32'd7, 4'd10, 32'd0, DIV_CYC);
        runOp("UMOD 100/7", 3'd7, 32'd100, 32'd7, 4'd11, 32'd0, DIV_CYC);
        runOp("UDIV 5/0",   3'd6, 32'd5, 32'd0, 4'd12, 32'd0, DIV_CYC);
        runOp("UMOD 5/0",   3'd7, 32'd5, 32'd0, 4'd13, 32'd0, DIV_CYC);
`endif

        // Start while busy is ignored
        begin
            int cyc;
            applyStimulus(3'd5, 32'd3, 32'd4, 4'd3);
            repeat (5) @(negedge clk);
            applyStimulus(3'd0, 32'd1, 32'd2, 4'd5);
            waitDone(cyc);
            checkOutput("busy-ignore result",   bus.ALUResult, 32'd12);
            checkOutput("busy-ignore WriteReg", 32'(bus.WriteReg), 32'd3);
            repeat (3) @(negedge clk);
            checkOutput("busy-ignore no extra", bus.ALUResult, 32'd12);
        end

        // start held through completion: accepted only one edge after the strobe
        begin
            int cyc;
            applyStimulus(3'd5, 32'd2, 32'd3, 4'd4);
            @(posedge clk); #1;
            bus.start = 1'b1; bus.Op = 3'd0; bus.SrcA = 32'd10; bus.SrcB = 32'd20; bus.Rd = 4'd6;
            waitDone(cyc);
            checkOutput("hold MUL result",   bus.ALUResult, 32'd6);
            checkOutput("hold MUL WriteReg", 32'(bus.WriteReg), 32'd4);
            @(negedge clk);
            checkOutput("hold ADD result",   bus.ALUResult, 32'd30);
            checkOutput("hold ADD strobe",   32'(bus.RegWrite), 32'd1);
            @(posedge clk); #1 bus.start = 1'b0;
            repeat (2) @(negedge clk);
        end

        // Reset during an iterative op aborts it
        applyStimulus(3'd5, 32'd1234, 32'd5678, 4'd7);
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("abort busy",      32'(bus.busy), 32'd0);
        checkOutput("abort RegWrite",  32'(bus.RegWrite), 32'd0);
        checkOutput("abort ALUResult", bus.ALUResult, 32'd0);
        checkOutput("abort WriteReg",  32'(bus.WriteReg), 32'd0);
        checkOutput("abort Zero",      32'(bus.Zero), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checkOutput("abort no strobe", 32'(bus.RegWrite), 32'd0);
        end
        runOp("ADD 1+1 after reset", 3'd0, 32'd1, 32'd1, 4'd1, 32'd2, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end
endmodule
